// File: rtl/ram_port_arbiter.sv
// Purpose: round-robin sharing of one SDP RAM (1 wr + 1 rd port) between two requesters.
// Latency: acks are combinational; RAM strobes registered (+1); read data tagged back at ack+3.
// Backpressure: a requester holds its request until acked; read return has no backpressure.
module ram_port_arbiter #(
    parameter int p_addresswidth = 4,
    parameter int p_datawidth    = 16
) (
    input  logic                      inclk,
    input  logic                      inrst_n,

    input  logic                      in_req0,
    input  logic                      in_we0,
    input  logic [p_addresswidth-1:0] in_addr0,
    input  logic [p_datawidth-1:0]    in_data0,
    output logic                      out_ack0,
    output logic                      out_rdvalid0,

    input  logic                      in_req1,
    input  logic                      in_we1,
    input  logic [p_addresswidth-1:0] in_addr1,
    input  logic [p_datawidth-1:0]    in_data1,
    output logic                      out_ack1,
    output logic                      out_rdvalid1,

    output logic [p_datawidth-1:0]    out_rddata,

    output logic                      out_ram_wren,
    output logic [p_addresswidth-1:0] out_ram_wraddress,
    output logic [p_datawidth-1:0]    out_ram_wrdata,
    output logic [p_addresswidth-1:0] out_ram_rdaddress,
    input  logic [p_datawidth-1:0]    in_ram_rddata
);

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    localparam int c_tag_stages = 3;

    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic [1:0] wr_gnt;
    logic [1:0] rd_gnt;
    logic       wr_ptr;
    logic       rd_ptr;

    logic [p_addresswidth-1:0] wr_sel_addr;
    logic [p_datawidth-1:0]    wr_sel_data;
    logic [p_addresswidth-1:0] rd_sel_addr;
    rd_tag_t                   rd_tag_new;
    rd_tag_t [c_tag_stages-1:0] tag_q;

    // ptr=0 favours requester 0 on contention, ptr=1 favours requester 1
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
        return gnt;
    endfunction

    always_comb begin
        wr_req = {in_req1 & in_we1,  in_req0 & in_we0};
        rd_req = {in_req1 & ~in_we1, in_req0 & ~in_we0};
        wr_gnt = 2'b00;
        rd_gnt = 2'b00;
        if (inrst_n) begin
            wr_gnt = rr_pick(wr_req, wr_ptr);
            rd_gnt = rr_pick(rd_req, rd_ptr);
        end
    end

    assign out_ack0 = wr_gnt[0] | rd_gnt[0];
    assign out_ack1 = wr_gnt[1] | rd_gnt[1];

    always_comb begin
        wr_sel_addr    = wr_gnt[1] ? in_addr1 : in_addr0;
        wr_sel_data    = wr_gnt[1] ? in_data1 : in_data0;
        rd_sel_addr    = rd_gnt[1] ? in_addr1 : in_addr0;
        rd_tag_new.vld = |rd_gnt;
        rd_tag_new.id  = rd_gnt[1];
    end

    // Pointers move only on contention, always to the requester that lost
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_req == 2'b11) begin
                wr_ptr <= wr_gnt[0];
            end
            if (rd_req == 2'b11) begin
                rd_ptr <= rd_gnt[0];
            end
        end
    end

    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            out_ram_wren      <= 1'b0;
            out_ram_wraddress <= '0;
            out_ram_wrdata    <= '0;
            out_ram_rdaddress <= '0;
        end else begin
            out_ram_wren <= |wr_gnt;
            if (|wr_gnt) begin
                out_ram_wraddress <= wr_sel_addr;
                out_ram_wrdata    <= wr_sel_data;
            end
            if (|rd_gnt) begin
                out_ram_rdaddress <= rd_sel_addr;
            end
        end
    end

    // Tag stages track address register, RAM address register, RAM output register
    always_ff @(posedge inclk) begin
        if (!inrst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[c_tag_stages-2:0], rd_tag_new};
        end
    end

    assign out_rdvalid0 = tag_q[c_tag_stages-1].vld & ~tag_q[c_tag_stages-1].id;
    assign out_rdvalid1 = tag_q[c_tag_stages-1].vld &  tag_q[c_tag_stages-1].id;
    assign out_rddata   = in_ram_rddata;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one simple-dual-port buffered RAM between two requesters. The RAM has one write port, one read port, registered read address and registered read data.
- Each cycle the arbiter runs independent round-robin arbitration for the write port and for the read port.
- RAM-side signals are registered. Read data returns to the issuing requester, tagged by a per-requester valid strobe.
- Sits between the USB/MIPI command engines and the RAM instance.

Parameters:
p_addresswidth, 4, RAM address bits
p_datawidth, 16, RAM data bits

Ports:
inclk  input  1  system clock, all logic on rising edge
inrst_n  input  1  synchronous active-low reset
in_req0  input  1  requester 0 request; held until out_ack0
in_we0  input  1  requester 0 op: 1=write, 0=read
in_addr0  input  p_addresswidth  requester 0 address
in_data0  input  p_datawidth  requester 0 write data
out_ack0  output  1  requester 0 accepted this cycle (combinational)
out_rdvalid0  output  1  out_rddata belongs to requester 0 this cycle
in_req1, in_we1, in_addr1, in_data1, out_ack1, out_rdvalid1  same as above for requester 1
out_rddata  output  p_datawidth  shared read-return bus
out_ram_wren  output  1  to RAM write enable (registered)
out_ram_wraddress  output  p_addresswidth  to RAM write address (registered)
out_ram_wrdata  output  p_datawidth  to RAM write data (registered)
out_ram_rdaddress  output  p_addresswidth  to RAM read address (registered)
in_ram_rddata  input  p_datawidth  from RAM read data

Behaviour:
- Reset: applies on an inclk edge with inrst_n=0.
  - out_ram_wren=0, out_ram_wraddress=0, out_ram_wrdata=0, out_ram_rdaddress=0.
  - Read-tag pipeline cleared, so out_rdvalid0/1=0 from the next cycle.
  - out_ack0/1=0 while inrst_n=0.
  - Both round-robin pointers point at requester 0 (requester 0 wins the first contention).
- Request classes:
  - Write request: reqN=1 and weN=1.
  - Read request: reqN=1 and weN=0.
  - One op per requester per cycle.
- Write arbitration (combinational):
  - Single write requester: granted.
  - Both write: grant the requester the write pointer favours.
  - Write pointer flips to the non-granted requester only when a contended grant occurs.
- Read arbitration: identical, with its own independent pointer.
- out_ackN = write grant N OR read grant N. A read and a write from different requesters are both acked in the same cycle.
- A requester not acked must hold req/we/addr/data stable. Ack is the only handshake; no backpressure on read return.
- RAM-side registers, loaded at the edge ending ack cycle T:
  - On write grant: out_ram_wren=1, wraddress/wrdata = granted requester's values. Otherwise out_ram_wren=0; address/data keep their last values.
  - On read grant: out_ram_rdaddress = granted address. Otherwise it holds.
- Read latency:
  - Tag pipeline: 3 stages of {valid, id}.
  - The read acked in cycle T gives out_rdvalid(id)=1 during cycle T+3, with out_rddata = in_ram_rddata (combinational pass-through) in that cycle.
  - Breakdown: T+1 address at RAM, T+2 RAM address register, T+3 RAM output register.
- Throughput: one read and one write per cycle sustained. Back-to-back reads give consecutive valid cycles with correct ids.
- At most one of out_rdvalid0/1 is high in any cycle.
- out_rddata is don't-care when both valids are 0.
- Hazards, no interlock in the arbiter:
  - Write and read to the same address acked in the same cycle: the read returns OLD data.
  - Write acked in T, read of the same address acked in T+1 or later: the read returns NEW data.
- Reset mid-operation: in-flight reads are discarded (no valid strobe). The RAM write of a grant made in the reset cycle is suppressed.

Test Plan:
- Reset: hold inrst_n=0 for 3 cycles with both requesters requesting -> no acks, out_ram_wren=0, all out_rdvalid=0; after release, requester 0 is acked first on a contended write.
- Requester 0 writes 0xA5A5 to addr 3 (ack T0), then reads addr 3 (ack T1) -> out_ram_wren=1 in T0+1; out_rdvalid0=1 in T1+3 with out_rddata=0xA5A5; out_rdvalid1 stays 0.
- Both requesters write continuously for 4 cycles -> acks alternate 0,1,0,1; RAM writes follow that order with the matching data.
- Addr 5 holds 0x1111. Requester 0 writes 0x2222 to addr 5 while requester 1 reads addr 5 in the same cycle -> both acked; out_rdvalid1 returns 0x1111; a repeat read returns 0x2222.
- Both requesters issue 4 reads each to distinct preloaded addresses -> 8 consecutive valid cycles, ids alternating, each data matching its address.
- Reads acked in T and T+1, reset asserted in T+2 -> no out_rdvalid in T+3/T+4.
